// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the clock/reset sequencer.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,
        ST_LOCKW  = 3'd1,
        ST_CCCRST = 3'd2,
        ST_SYSREL = 3'd3,
        ST_CAMREL = 3'd4,
        ST_RUN    = 3'd5
    } state_e;

    localparam int CCC_RST_PULSE = 16;
    localparam int SYNC_STAGES   = 2;

    // States in which loss of lock tears the downstream resets back down.
    function automatic logic lock_monitored(input state_e s);
        logic mon;
        case (s)
            ST_SYSREL, ST_CAMREL, ST_RUN: mon = 1'b1;
            default:                      mon = 1'b0;
        endcase
        return mon;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for a single asynchronous level, cleared by reset.
module sync_2ff
    import clk_rst_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_rst_sequencer.sv
// Power-up sequencer: oscillator settle, CCC lock qualification, then ordered
// release of system, camera and LCD resets with lock-loss recovery.
module clk_rst_sequencer
    import clk_rst_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000,
    parameter int LOCK_STABLE   = 64,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int CAM_DELAY     = 5000,
    parameter int LCD_DELAY     = 5000,
    parameter int CNT_W         = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CCC_LOCK,
    input  logic       SOFT_RST_REQ,
    output logic       CCC_RESET,
    output logic       SYS_RESET,
    output logic       CAM_PWDN,
    output logic       CAM_RESET_N,
    output logic       LCD_RESET,
    output logic       READY,
    output logic       LOCK_TO_FLAG,
    output logic [2:0] STATE_DBG
);

    localparam longint CNT_LIMIT = (64'd1 << CNT_W) - 64'd1;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > CNT_LIMIT ||
        LOCK_STABLE   < 1 || LOCK_STABLE   > CNT_LIMIT ||
        LOCK_TIMEOUT  < 1 || LOCK_TIMEOUT  > CNT_LIMIT ||
        CAM_DELAY     < 1 || CAM_DELAY     > CNT_LIMIT ||
        LCD_DELAY     < 1 || LCD_DELAY     > CNT_LIMIT) begin : g_param_check
        $error("clk_rst_sequencer: cycle parameter outside 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(CCC_RST_PULSE - 1);
    localparam logic [CNT_W-1:0] CAM_LAST    = CNT_W'(CAM_DELAY - 1);
    localparam logic [CNT_W-1:0] LCD_LAST    = CNT_W'(LCD_DELAY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stable_q, stable_d;
    logic             ccc_reset_q, ccc_reset_d;
    logic             sys_reset_q, sys_reset_d;
    logic             cam_pwdn_q, cam_pwdn_d;
    logic             cam_reset_n_q, cam_reset_n_d;
    logic             lcd_reset_q, lcd_reset_d;
    logic             ready_q, ready_d;
    logic             lock_to_q, lock_to_d;
    logic             lock_gated_s;
    logic             lk_s;

    // Lock reported while the CCC is held in reset is meaningless, so it is
    // masked before the synchroniser and qualification restarts after release.
    assign lock_gated_s = CCC_LOCK & ~ccc_reset_q;

    sync_2ff u_lock_sync (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (lock_gated_s),
        .q_o   (lk_s)
    );

    // Next-state, counters and output decode from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        stable_d  = stable_q;
        lock_to_d = lock_to_q;

        case (state_q)
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = ST_LOCKW;
                else                      state_d = ST_SETTLE;
            end
            ST_LOCKW: begin
                if (lk_s) stable_d = (stable_q == CNT_MAX) ? stable_q : stable_q + CNT_ONE;
                else      stable_d = '0;
                if (lk_s && stable_q >= STABLE_LAST) begin
                    state_d = ST_SYSREL;
                end else if (cnt_q >= TO_LAST) begin
                    state_d   = ST_CCCRST;
                    lock_to_d = 1'b1;
                end else begin
                    state_d = ST_LOCKW;
                end
            end
            ST_CCCRST: begin
                if (cnt_q == PULSE_LAST) state_d = ST_LOCKW;
                else                     state_d = ST_CCCRST;
            end
            ST_SYSREL: begin
                if (!lk_s)                 state_d = ST_LOCKW;
                else if (cnt_q == CAM_LAST) state_d = ST_CAMREL;
                else                       state_d = ST_SYSREL;
            end
            ST_CAMREL: begin
                if (!lk_s)                 state_d = ST_LOCKW;
                else if (cnt_q == LCD_LAST) state_d = ST_RUN;
                else                       state_d = ST_CAMREL;
            end
            ST_RUN: begin
                if (!lk_s) state_d = ST_LOCKW;
                else       state_d = ST_RUN;
            end
            default: state_d = ST_SETTLE;
        endcase

        if (SOFT_RST_REQ && state_q != ST_SETTLE) begin
            state_d = ST_SETTLE;
        end else begin
            state_d = state_d;
        end

        if (state_d != state_q) begin
            cnt_d    = '0;
            stable_d = '0;
        end else begin
            cnt_d = cnt_d;
        end

        ccc_reset_d   = (state_d == ST_SETTLE) || (state_d == ST_CCCRST);
        sys_reset_d   = !lock_monitored(state_d);
        cam_reset_n_d = (state_d == ST_CAMREL) || (state_d == ST_RUN);
        lcd_reset_d   = (state_d != ST_RUN);
        ready_d       = (state_d == ST_RUN);
        // Camera stays powered across lock-loss recovery; only a full restart re-asserts it.
        if (state_d == ST_SETTLE)          cam_pwdn_d = 1'b1;
        else if (lock_monitored(state_d))  cam_pwdn_d = 1'b0;
        else                               cam_pwdn_d = cam_pwdn_q;
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_SETTLE;
            cnt_q         <= '0;
            stable_q      <= '0;
            ccc_reset_q   <= 1'b1;
            sys_reset_q   <= 1'b1;
            cam_pwdn_q    <= 1'b1;
            cam_reset_n_q <= 1'b0;
            lcd_reset_q   <= 1'b1;
            ready_q       <= 1'b0;
            lock_to_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            ccc_reset_q   <= ccc_reset_d;
            sys_reset_q   <= sys_reset_d;
            cam_pwdn_q    <= cam_pwdn_d;
            cam_reset_n_q <= cam_reset_n_d;
            lcd_reset_q   <= lcd_reset_d;
            ready_q       <= ready_d;
            lock_to_q     <= lock_to_d;
        end
    end

    assign CCC_RESET    = ccc_reset_q;
    assign SYS_RESET    = sys_reset_q;
    assign CAM_PWDN     = cam_pwdn_q;
    assign CAM_RESET_N  = cam_reset_n_q;
    assign LCD_RESET    = lcd_reset_q;
    assign READY        = ready_q;
    assign LOCK_TO_FLAG = lock_to_q;
    assign STATE_DBG    = state_q;

endmodule
